// File: rtl/gen_arb_rr_lock_if.sv
// Request/grant bundle for gen_arb_rr_lock_top: the requesters drive rqsts,
// and the arbiter returns a registered one-hot grant with its binary index.
interface gen_arb_rr_lock_if #(
  parameter int WID = 4
) ();
  localparam int IDX_WID = $clog2(WID);

  logic [WID-1:0]     rqsts;
  logic [WID-1:0]     grnts;
  logic               grnt_vld;
  logic [IDX_WID-1:0] grnt_idx;

  modport master (output rqsts, input grnts, input grnt_vld, input grnt_idx);
  modport slave  (input rqsts, output grnts, output grnt_vld, output grnt_idx);
endinterface

// File: rtl/gen_arb_rr_lock_top.sv
// Registered round-robin arbiter with grant locking and direct handoff.
// Define GEN_ARB_RR_HOLD_LIMIT_EN to cap a winner's hold at MAX_HOLD cycles.
module gen_arb_rr_lock_top #(
  parameter int WID      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gen_arb_rr_lock_if.slave  bus
);
  localparam int IDX_WID = $clog2(WID);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} fsm_t;

  if (WID < 2 || MAX_HOLD < 1) begin : g_param_chk
    $error("gen_arb_rr_lock_top: requires WID >= 2 and MAX_HOLD >= 1");
  end

  fsm_t               fsm_r, fsm_s;
  logic [IDX_WID-1:0] ptr_r, ptr_s;
  logic [IDX_WID-1:0] cur_r, cur_s;
  logic [IDX_WID-1:0] nxt_s;
  logic [WID-1:0]     others_s;
  logic               release_s;
  logic               expire_s;
  logic [WID-1:0]     grnts_r;
  logic               grnt_vld_r;
  logic [IDX_WID-1:0] grnt_idx_r;

`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
  localparam int CNT_WID = $clog2(MAX_HOLD + 1);
  logic [CNT_WID-1:0] hold_cnt_r, hold_cnt_s;
`endif

  function automatic logic [IDX_WID-1:0] lsb_pick(input logic [WID-1:0] v);
    logic [IDX_WID-1:0] idx;
    idx = {IDX_WID{1'b0}};
    for (int i = WID - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_WID'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Prefer requesters at or above p; fall back to the lowest set bit to wrap.
  function automatic logic [IDX_WID-1:0] rr_pick(input logic [WID-1:0] v,
                                                 input logic [IDX_WID-1:0] p);
    logic [WID-1:0] masked;
    masked = v & ~((WID'(1'b1) << p) - WID'(1'b1));
    if (masked != {WID{1'b0}}) begin
      return lsb_pick(masked);
    end else begin
      return lsb_pick(v);
    end
  endfunction

  // Next-state: arbitration from IDLE, lock/release/handoff while in GRANT.
  always_comb begin
    fsm_s     = fsm_r;
    ptr_s     = ptr_r;
    cur_s     = cur_r;
    nxt_s     = (cur_r == IDX_WID'(WID - 1)) ? {IDX_WID{1'b0}} : cur_r + IDX_WID'(1'b1);
    others_s  = bus.rqsts & ~(WID'(1'b1) << cur_r);
    release_s = ~bus.rqsts[cur_r];
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
    hold_cnt_s = hold_cnt_r;
    expire_s   = bus.rqsts[cur_r] && (hold_cnt_r == CNT_WID'(MAX_HOLD - 1));
`else
    expire_s   = 1'b0;
`endif
    case (fsm_r)
      IDLE: begin
        if (bus.rqsts != {WID{1'b0}}) begin
          fsm_s = GRANT;
          cur_s = rr_pick(bus.rqsts, ptr_r);
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
          hold_cnt_s = {CNT_WID{1'b0}};
`endif
        end else begin
          fsm_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s || expire_s) begin
          ptr_s = nxt_s;
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
          hold_cnt_s = {CNT_WID{1'b0}};
`endif
          if (others_s != {WID{1'b0}}) begin
            cur_s = rr_pick(others_s, nxt_s);
          end else if (release_s) begin
            fsm_s = IDLE;
          end else begin
            // Forced expiry with nobody waiting: the same winner keeps the grant.
            cur_s = cur_r;
          end
        end else begin
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
          hold_cnt_s = hold_cnt_r + CNT_WID'(1'b1);
`endif
          fsm_s = GRANT;
        end
      end
      default: begin
        fsm_s = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are a registered image of next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r      <= IDLE;
      ptr_r      <= {IDX_WID{1'b0}};
      cur_r      <= {IDX_WID{1'b0}};
      grnts_r    <= {WID{1'b0}};
      grnt_vld_r <= 1'b0;
      grnt_idx_r <= {IDX_WID{1'b0}};
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
      hold_cnt_r <= {CNT_WID{1'b0}};
`endif
    end else begin
      fsm_r      <= fsm_s;
      ptr_r      <= ptr_s;
      cur_r      <= cur_s;
      grnts_r    <= (fsm_s == GRANT) ? (WID'(1'b1) << cur_s) : {WID{1'b0}};
      grnt_vld_r <= (fsm_s == GRANT);
      grnt_idx_r <= cur_s;
`ifdef GEN_ARB_RR_HOLD_LIMIT_EN
      hold_cnt_r <= hold_cnt_s;
`endif
    end
  end

  assign bus.grnts    = grnts_r;
  assign bus.grnt_vld = grnt_vld_r;
  assign bus.grnt_idx = grnt_idx_r;
endmodule
